arb_requester: RTL and testbench
================================

ARB_REQUESTER -- requirements
Module: arb_requester

Interface
REQ-001 Parameter DATA_W, default 8, SHALL set the bus_data and cmd_data width.
REQ-002 Parameter LEN_W, default 4, SHALL set the cmd_len width; maximum burst is 2^LEN_W-1 beats.
REQ-003 Parameter TIMEOUT, default 15, SHALL set the number of sampled gnt=0 cycles in REQ before abandoning; range 1..255.
REQ-004 clock  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-005 reset  input  1  SHALL be asynchronous, active-high; asserting it immediately forces reset values.
REQ-006 cmd_valid  input  1  SHALL be high when a burst command is offered.
REQ-007 cmd_len  input  LEN_W  SHALL be the burst length in beats.
REQ-008 cmd_data  input  DATA_W  SHALL be the first beat value.
REQ-009 cmd_ready  output  1  SHALL be high when a command can be accepted (registered).
REQ-010 req  output  1  SHALL be the registered request to the arbiter.
REQ-011 gnt  input  1  SHALL be the grant from the arbiter, sampled only on rising clock edges.
REQ-012 bus_valid  output  1  SHALL mark a valid beat on bus_data (registered).
REQ-013 bus_data  output  DATA_W  SHALL carry beat data (registered).
REQ-014 done  output  1  SHALL pulse one cycle on burst completion.
REQ-015 timeout_err  output  1  SHALL pulse one cycle when a request is abandoned.

Function
REQ-016 FSM states SHALL be IDLE, REQ, XFER, RELEASE.
REQ-017 IDLE: cmd_ready=1; an edge with cmd_valid&cmd_ready SHALL latch cmd_len/cmd_data and drop cmd_ready the next cycle.
REQ-018 Accept with cmd_len=0: SHALL stay IDLE, never assert req, pulse done the cycle after accept, cmd_ready=0 for that cycle only.
REQ-019 Accept with cmd_len>0: SHALL enter REQ with req=1 the cycle after accept and clear the wait counter.
REQ-020 REQ: each edge sampling gnt=0 SHALL increment the wait counter; the edge where it reaches TIMEOUT SHALL give req=0, timeout_err=1 (one cycle), cmd_ready=1, state IDLE next cycle.
REQ-021 REQ: an edge sampling gnt=1 SHALL enter XFER and emit beat 0 next cycle; gnt=1 on the same edge as timeout SHALL win (no error).
REQ-022 Beat k SHALL have bus_data = cmd_data + k modulo 2^DATA_W (wraps, no carry out).
REQ-023 In REQ/XFER, each edge sampling gnt=1 with beats remaining SHALL emit the next beat (bus_valid=1) in the following cycle; an edge sampling gnt=0 SHALL give bus_valid=0 and hold the beat index.
REQ-024 XFER has no timeout; req SHALL remain 1 while gnt is withdrawn mid-burst.
REQ-025 The edge emitting the final beat SHALL also set req=0 and state RELEASE.
REQ-026 RELEASE: bus_valid=0; the first edge sampling gnt=0 SHALL pulse done and set cmd_ready=1 in the same following cycle, state IDLE.
REQ-027 bus_data SHALL hold its last value when bus_valid=0.
REQ-028 cmd_valid outside IDLE SHALL be ignored; exactly one of done/timeout_err SHALL pulse per accepted command.

Reset
REQ-029 While reset=1: state IDLE; req, bus_valid, done, timeout_err, cmd_ready, bus_data, counters all 0.
REQ-030 cmd_ready SHALL rise on the first rising edge after reset deassertion.
REQ-031 Reset mid-burst SHALL abort without done or timeout_err; remaining beats are discarded.

Verification
REQ-032 cmd_len=3, cmd_data=0x10, gnt rises 2 cycles after req -> bus_data 0x10,0x11,0x12 on 3 consecutive bus_valid cycles; req falls with beat 0x12; done pulses once gnt sampled 0.
REQ-033 cmd_data=0xFE, cmd_len=3 -> beats 0xFE,0xFF,0x00.
REQ-034 cmd_len=0 -> req stays 0, done pulses one cycle after accept, cmd_ready back next cycle.
REQ-035 TIMEOUT=15, gnt held 0 -> req high exactly 15 cycles, timeout_err single pulse, no bus_valid, cmd_ready=1; gnt arriving on 15th edge -> burst proceeds, no error.
REQ-036 cmd_len=4, gnt drops for 3 cycles after beat 1 -> bus_valid low 3 cycles, req stays 1, then beats 2,3 follow without loss or duplication.
REQ-037 reset asserted asynchronously during beat 2 of 5 -> all outputs 0 immediately, no done; new command after release runs normally.

Source files
------------

// File: rtl/arb_requester_if.sv
// Command, arbiter and data-bus signals between a burst requester and its surroundings.
interface arb_requester_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned LEN_W  = 4
);
  logic              cmd_valid;
  logic [LEN_W-1:0]  cmd_len;
  logic [DATA_W-1:0] cmd_data;
  logic              cmd_ready;
  logic              req;
  logic              gnt;
  logic              bus_valid;
  logic [DATA_W-1:0] bus_data;
  logic              done;
  logic              timeout_err;

  modport master (
    input  cmd_valid, cmd_len, cmd_data, gnt,
    output cmd_ready, req, bus_valid, bus_data, done, timeout_err
  );

  modport slave (
    output cmd_valid, cmd_len, cmd_data, gnt,
    input  cmd_ready, req, bus_valid, bus_data, done, timeout_err
  );
endinterface

// File: rtl/arb_requester.sv
// Burst requester: accepts a command, requests the arbiter, emits incrementing beats while granted.
module arb_requester #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned LEN_W   = 4,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic           clk,
  input  logic           rst,
  arb_requester_if.master bus
);

  typedef enum logic [1:0] {IDLE, REQ, XFER, RELEASE} state_e;

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  beat_q, beat_d;
  logic [DATA_W-1:0] base_q, base_d;
  logic [7:0]        wait_q, wait_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              req_q, req_d;
  logic              bus_valid_q, bus_valid_d;
  logic [DATA_W-1:0] bus_data_q, bus_data_d;
  logic              done_q, done_d;
  logic              timeout_err_q, timeout_err_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      len_q         <= '0;
      beat_q        <= '0;
      base_q        <= '0;
      wait_q        <= '0;
      cmd_ready_q   <= 1'b0;
      req_q         <= 1'b0;
      bus_valid_q   <= 1'b0;
      bus_data_q    <= '0;
      done_q        <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      len_q         <= len_d;
      beat_q        <= beat_d;
      base_q        <= base_d;
      wait_q        <= wait_d;
      cmd_ready_q   <= cmd_ready_d;
      req_q         <= req_d;
      bus_valid_q   <= bus_valid_d;
      bus_data_q    <= bus_data_d;
      done_q        <= done_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    len_d         = len_q;
    beat_d        = beat_q;
    base_d        = base_q;
    wait_d        = wait_q;
    cmd_ready_d   = cmd_ready_q;
    req_d         = req_q;
    bus_valid_d   = 1'b0;
    bus_data_d    = bus_data_q;
    done_d        = 1'b0;
    timeout_err_d = 1'b0;

    case (state_q)
      IDLE: begin
        cmd_ready_d = 1'b1;
        if (bus.cmd_valid && cmd_ready_q) begin
          cmd_ready_d = 1'b0;
          len_d       = bus.cmd_len;
          base_d      = bus.cmd_data;
          beat_d      = '0;
          wait_d      = '0;
          if (bus.cmd_len == '0) begin
            done_d = 1'b1;
          end else begin
            req_d   = 1'b1;
            state_d = REQ;
          end
        end
      end
      // Grant is checked before the wait counter so a grant on the timeout edge wins.
      REQ, XFER: begin
        if (bus.gnt) begin
          bus_valid_d = 1'b1;
          bus_data_d  = base_q + DATA_W'(beat_q);
          beat_d      = beat_q + 1'b1;
          state_d     = XFER;
          if (beat_q == len_q - 1'b1) begin
            req_d   = 1'b0;
            state_d = RELEASE;
          end
        end else if (state_q == REQ) begin
          wait_d = wait_q + 8'd1;
          if (wait_q == 8'(TIMEOUT - 1)) begin
            req_d         = 1'b0;
            timeout_err_d = 1'b1;
            cmd_ready_d   = 1'b1;
            state_d       = IDLE;
          end
        end
      end
      RELEASE: begin
        if (!bus.gnt) begin
          done_d      = 1'b1;
          cmd_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.cmd_ready   = cmd_ready_q;
  assign bus.req         = req_q;
  assign bus.bus_valid   = bus_valid_q;
  assign bus.bus_data    = bus_data_q;
  assign bus.done        = done_q;
  assign bus.timeout_err = timeout_err_q;

endmodule

// File: tb/tb_arb_requester.sv
// Directed bench for arb_requester: per-cycle vector table plus hand-written corner sequences.
module tb_arb_requester;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  arb_requester_if #(.DATA_W(8), .LEN_W(4)) bus_if ();

  arb_requester #(.DATA_W(8), .LEN_W(4), .TIMEOUT(15)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        cv;
    logic [3:0]  len;
    logic [7:0]  data;
    logic        gnt;
    logic [12:0] exp;
  } vec_t;

  vec_t vecs [18];

  // Packed as {cmd_ready, req, bus_valid, done, timeout_err, bus_data}.
  function automatic logic [12:0] o(input bit rdy, input bit rq, input bit bv,
                                    input bit dn, input bit to, input logic [7:0] d);
    return {rdy, rq, bv, dn, to, d};
  endfunction

  function automatic logic [12:0] outs();
    return {bus_if.cmd_ready, bus_if.req, bus_if.bus_valid, bus_if.done,
            bus_if.timeout_err, bus_if.bus_data};
  endfunction

  task automatic chk(input string name, input logic [12:0] act, input logic [12:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got rdy/req/bv/done/to=%b data=%h, expected rdy/req/bv/done/to=%b data=%h",
               name, act[12:8], act[7:0], exp[12:8], exp[7:0]);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input logic cv, input logic [3:0] len, input logic [7:0] data, input logic g);
    @(negedge clk);
    bus_if.cmd_valid = cv;
    bus_if.cmd_len   = len;
    bus_if.cmd_data  = data;
    bus_if.gnt       = g;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int reqcnt, tocnt, bvcnt, dncnt;
    logic [12:0] pulse_out;

    bus_if.cmd_valid = 1'b0;
    bus_if.cmd_len   = '0;
    bus_if.cmd_data  = '0;
    bus_if.gnt       = 1'b0;

    vecs[0]  = '{1'b0, 4'd0, 8'h00, 1'b0, o(1,0,0,0,0,8'h00)};
    vecs[1]  = '{1'b1, 4'd3, 8'h10, 1'b0, o(0,1,0,0,0,8'h00)};
    vecs[2]  = '{1'b0, 4'd0, 8'h00, 1'b0, o(0,1,0,0,0,8'h00)};
    vecs[3]  = '{1'b0, 4'd0, 8'h00, 1'b0, o(0,1,0,0,0,8'h00)};
    vecs[4]  = '{1'b0, 4'd0, 8'h00, 1'b1, o(0,1,1,0,0,8'h10)};
    vecs[5]  = '{1'b1, 4'd5, 8'hAA, 1'b1, o(0,1,1,0,0,8'h11)};
    vecs[6]  = '{1'b0, 4'd0, 8'h00, 1'b1, o(0,0,1,0,0,8'h12)};
    vecs[7]  = '{1'b0, 4'd0, 8'h00, 1'b1, o(0,0,0,0,0,8'h12)};
    vecs[8]  = '{1'b0, 4'd0, 8'h00, 1'b0, o(1,0,0,1,0,8'h12)};
    vecs[9]  = '{1'b0, 4'd0, 8'h00, 1'b0, o(1,0,0,0,0,8'h12)};
    vecs[10] = '{1'b1, 4'd3, 8'hFE, 1'b1, o(0,1,0,0,0,8'h12)};
    vecs[11] = '{1'b0, 4'd0, 8'h00, 1'b1, o(0,1,1,0,0,8'hFE)};
    vecs[12] = '{1'b1, 4'd5, 8'hAA, 1'b1, o(0,1,1,0,0,8'hFF)};
    vecs[13] = '{1'b0, 4'd0, 8'h00, 1'b1, o(0,0,1,0,0,8'h00)};
    vecs[14] = '{1'b0, 4'd0, 8'h00, 1'b0, o(1,0,0,1,0,8'h00)};
    vecs[15] = '{1'b1, 4'd0, 8'h55, 1'b0, o(0,0,0,1,0,8'h00)};
    vecs[16] = '{1'b1, 4'd3, 8'h77, 1'b0, o(1,0,0,0,0,8'h00)};
    vecs[17] = '{1'b0, 4'd0, 8'h00, 1'b0, o(1,0,0,0,0,8'h00)};

    #12;
    chk("reset_state", outs(), o(0,0,0,0,0,8'h00));
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 18; i++) begin
      step(vecs[i].cv, vecs[i].len, vecs[i].data, vecs[i].gnt);
      chk($sformatf("vec%0d", i), outs(), vecs[i].exp);
    end

    // Timeout with grant never arriving
    step(1'b1, 4'd2, 8'h20, 1'b0);
    reqcnt = int'(bus_if.req);
    tocnt = 0; bvcnt = 0; dncnt = 0;
    pulse_out = '0;
    for (int i = 0; i < 30; i++) begin
      step(1'b0, 4'd0, 8'h00, 1'b0);
      reqcnt += int'(bus_if.req);
      bvcnt  += int'(bus_if.bus_valid);
      dncnt  += int'(bus_if.done);
      if (bus_if.timeout_err) begin
        tocnt++;
        pulse_out = outs();
      end
    end
    chk_int("timeout_req_cycles", reqcnt, 15);
    chk_int("timeout_pulses", tocnt, 1);
    chk_int("timeout_no_beats", bvcnt, 0);
    chk_int("timeout_no_done", dncnt, 0);
    chk("timeout_pulse_cycle", pulse_out, o(1,0,0,0,1,8'h00));
    chk("timeout_idle", outs(), o(1,0,0,0,0,8'h00));

    // Grant on the 15th sampling edge beats the timeout
    step(1'b1, 4'd2, 8'h20, 1'b0);
    chk("g15_accept", outs(), o(0,1,0,0,0,8'h00));
    for (int i = 0; i < 14; i++) step(1'b0, 4'd0, 8'h00, 1'b0);
    chk("g15_waiting", outs(), o(0,1,0,0,0,8'h00));
    step(1'b0, 4'd0, 8'h00, 1'b1);
    chk("g15_beat0", outs(), o(0,1,1,0,0,8'h20));
    step(1'b0, 4'd0, 8'h00, 1'b1);
    chk("g15_beat1", outs(), o(0,0,1,0,0,8'h21));
    step(1'b0, 4'd0, 8'h00, 1'b0);
    chk("g15_done", outs(), o(1,0,0,1,0,8'h21));

    // Grant withdrawn for three cycles mid-burst
    step(1'b1, 4'd4, 8'h30, 1'b0);
    chk("drop_accept", outs(), o(0,1,0,0,0,8'h21));
    step(1'b0, 4'd0, 8'h00, 1'b1);
    chk("drop_beat0", outs(), o(0,1,1,0,0,8'h30));
    step(1'b0, 4'd0, 8'h00, 1'b1);
    chk("drop_beat1", outs(), o(0,1,1,0,0,8'h31));
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 4'd0, 8'h00, 1'b0);
      chk($sformatf("drop_gap%0d", i), outs(), o(0,1,0,0,0,8'h31));
    end
    step(1'b0, 4'd0, 8'h00, 1'b1);
    chk("drop_beat2", outs(), o(0,1,1,0,0,8'h32));
    step(1'b0, 4'd0, 8'h00, 1'b1);
    chk("drop_beat3", outs(), o(0,0,1,0,0,8'h33));
    step(1'b0, 4'd0, 8'h00, 1'b0);
    chk("drop_done", outs(), o(1,0,0,1,0,8'h33));

    // Asynchronous reset during beat 2 of 5
    step(1'b1, 4'd5, 8'h40, 1'b0);
    step(1'b0, 4'd0, 8'h00, 1'b1);
    step(1'b0, 4'd0, 8'h00, 1'b1);
    step(1'b0, 4'd0, 8'h00, 1'b1);
    chk("rst_beat2", outs(), o(0,1,1,0,0,8'h42));
    #2 rst = 1'b1;
    #1;
    chk("rst_async", outs(), o(0,0,0,0,0,8'h00));
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("rst_hold%0d", i), outs(), o(0,0,0,0,0,8'h00));
    end
    @(negedge clk);
    rst = 1'b0;
    bus_if.gnt = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_release", outs(), o(1,0,0,0,0,8'h00));
    step(1'b1, 4'd1, 8'h09, 1'b0);
    chk("post_rst_accept", outs(), o(0,1,0,0,0,8'h00));
    step(1'b0, 4'd0, 8'h00, 1'b1);
    chk("post_rst_beat", outs(), o(0,0,1,0,0,8'h09));
    step(1'b0, 4'd0, 8'h00, 1'b0);
    chk("post_rst_done", outs(), o(1,0,0,1,0,8'h09));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
